// File: rtl/uart_frame_accumulator.sv
// UART frame accumulator: collects bytes into a MAX_BYTES buffer until a TERM_LEN-byte terminator, with overflow/timeout errors.
// Optional XOR checksum over the payload enabled by UART_FRAME_ACC_CHECKSUM_EN.

module uart_frame_byte_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (we)      q <= din;
  end
endmodule

module uart_frame_accumulator #(
  parameter int                    MAX_BYTES = 128,
  parameter int                    TERM_LEN  = 2,
  parameter logic [8*TERM_LEN-1:0] TERM_SEQ  = 16'hBEEF,
  parameter int                    TIMEOUT   = 1026,
  localparam int                   SIZE_W    = $clog2(MAX_BYTES+1),
  localparam int                   CNT_W     = $clog2(MAX_BYTES+TERM_LEN+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             input_data,
  input  logic                   accumulate,
  input  logic                   frame_ack,
  output logic [8*MAX_BYTES-1:0] output_data,
  output logic [SIZE_W-1:0]      output_data_size,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic                   busy
);
  localparam int TW   = 8*TERM_LEN;
  localparam int TO_W = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE, S_ERROR} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [TO_W-1:0]  to_q;
  logic [TW-1:0]    hist_q;
  logic [CNT_W-1:0] cnt_inc, pay_len;
  logic [TW-1:0]    hist_d;
  logic             rearm, byte_evt, term_hit, ovf_hit, to_hit;
  logic             ck_bad, frame_ok, frame_bad;
  logic [SIZE_W-1:0] size_d;

  assign rearm    = frame_ack && (state_q == S_DONE || state_q == S_ERROR);
  assign byte_evt = accumulate && (state_q == S_IDLE || state_q == S_ACCUM);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign hist_d   = (hist_q << 8) | TW'(input_data);
  // Sliding window: the count guard stops the zeroed history from matching early.
  assign term_hit = byte_evt && (hist_d == TERM_SEQ) && (cnt_inc >= CNT_W'(TERM_LEN));
  assign ovf_hit  = byte_evt && !term_hit && (cnt_inc == CNT_W'(MAX_BYTES+TERM_LEN));
  assign to_hit   = (state_q == S_ACCUM) && !accumulate && (to_q == TO_W'(TIMEOUT-1));
  assign pay_len  = cnt_inc - CNT_W'(TERM_LEN);

`ifdef UART_FRAME_ACC_CHECKSUM_EN
  // xor_q folds in each byte as it leaves the history window, so at a match
  // it covers every payload byte ahead of the checksum byte now leaving.
  logic [7:0] xor_q;
  logic [7:0] out_byte;
  assign out_byte = hist_q[TW-1 -: 8];
  assign ck_bad   = (pay_len == '0) || (xor_q != out_byte);
  assign size_d   = SIZE_W'(pay_len - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset || rearm) xor_q <= '0;
    else if (byte_evt)  xor_q <= xor_q ^ out_byte;
  end
`else
  assign ck_bad = 1'b0;
  assign size_d = SIZE_W'(pay_len);
`endif

  assign frame_ok  = term_hit && !ck_bad;
  assign frame_bad = term_hit && ck_bad;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (frame_ok)                 state_d = S_DONE;
        else if (frame_bad || ovf_hit) state_d = S_ERROR;
        else if (byte_evt)            state_d = S_ACCUM;
        else if (to_hit)              state_d = S_ERROR;
      end
      S_DONE, S_ERROR: if (frame_ack) state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done  = (state_q == S_DONE);
    error = (state_q == S_ERROR);
    busy  = (state_q == S_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset || rearm) begin
      cnt_q            <= '0;
      to_q             <= '0;
      hist_q           <= '0;
      output_data_size <= '0;
      error_code       <= 2'd0;
    end else if (byte_evt) begin
      cnt_q  <= cnt_inc;
      to_q   <= '0;
      hist_q <= hist_d;
      if (frame_ok)  output_data_size <= size_d;
      if (frame_bad) error_code       <= 2'd3;
      if (ovf_hit)   error_code       <= 2'd1;
    end else if (state_q == S_ACCUM) begin
      if (to_hit) error_code <= 2'd2;
      else        to_q       <= to_q + TO_W'(1);
    end
  end

  // Lanes past MAX_BYTES do not exist, so late bytes fall on the floor.
  for (genvar i = 0; i < MAX_BYTES; i++) begin : g_lane
    uart_frame_byte_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (rearm),
      .we    (byte_evt && (cnt_q == CNT_W'(i))),
      .din   (input_data),
      .q     (output_data[8*i +: 8])
    );
  end
endmodule
